// File: rtl/pong_game_ctl.sv
// Pong game-flow sequencer: frame ticks from vsync, serve/play/point/over flow, scores and serve direction.
// Optional pause on a press during play when PONG_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | waiting for a press to start a new game
// SERVE | ball held centred for SERVE_FRAMES ticks
// PLAY  | ball moving, misses score a point
// POINT | ball frozen for POINT_FRAMES ticks, then serve again or game over
// OVER  | winner shown, press returns to IDLE
// PAUSE | (PONG_PAUSE_EN only) ball frozen until the next press
module pong_game_ctl #(
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_in,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       ball_en,
  output logic       ball_center,
  output logic       serve_dir,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
`ifdef PONG_PAUSE_EN
    , PAUSE = 3'd5
`endif
  } state_t;

  localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);

  state_t     state, state_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [3:0] score_left_n, score_right_n;
  logic [1:0] winner_n;
  logic       serve_dir_n;
  logic       vsync_q, start_q;
  logic       tick, press;

  assign tick      = vsync_in & ~vsync_q;
  assign press     = start & ~start_q;
  assign state_out = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      winner      <= 2'b00;
      serve_dir   <= 1'b0;
      ball_en     <= 1'b0;
      ball_center <= 1'b1;
      vsync_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state       <= state_n;
      frame_cnt   <= frame_cnt_n;
      score_left  <= score_left_n;
      score_right <= score_right_n;
      winner      <= winner_n;
      serve_dir   <= serve_dir_n;
      // Ball controls follow the registered state, so they lag a transition by one clock.
      ball_en     <= (state == PLAY);
      ball_center <= (state == IDLE) || (state == SERVE) || (state == OVER);
      vsync_q     <= vsync_in;
      start_q     <= start;
    end
  end

  always_comb begin
    state_n       = state;
    frame_cnt_n   = frame_cnt;
    score_left_n  = score_left;
    score_right_n = score_right;
    winner_n      = winner;
    serve_dir_n   = serve_dir;
    case (state)
      IDLE: begin
        if (press) begin
          score_left_n  = '0;
          score_right_n = '0;
          winner_n      = 2'b00;
          state_n       = SERVE;
        end
      end
      SERVE: begin
        if (tick && frame_cnt == SERVE_LAST) state_n = PLAY;
      end
      PLAY: begin
        if (miss_left && miss_right) begin
          serve_dir_n = ~serve_dir;
          state_n     = POINT;
        end else if (miss_left) begin
          score_right_n = (score_right == 4'd9) ? 4'd9 : score_right + 4'd1;
          serve_dir_n   = 1'b0;
          state_n       = POINT;
        end else if (miss_right) begin
          score_left_n = (score_left == 4'd9) ? 4'd9 : score_left + 4'd1;
          serve_dir_n  = 1'b1;
          state_n      = POINT;
        end
`ifdef PONG_PAUSE_EN
        else if (press) begin
          state_n = PAUSE;
        end
`endif
      end
      POINT: begin
        if (tick && frame_cnt == POINT_LAST) begin
          if (score_left == WIN_VAL) begin
            winner_n = 2'b01;
            state_n  = OVER;
          end else if (score_right == WIN_VAL) begin
            winner_n = 2'b10;
            state_n  = OVER;
          end else begin
            state_n = SERVE;
          end
        end
      end
      OVER: begin
        if (press) state_n = IDLE;
      end
`ifdef PONG_PAUSE_EN
      PAUSE: begin
        if (press) state_n = PLAY;
      end
`endif
      default: state_n = IDLE;
    endcase
    // Count starts from zero on every entry, even when a tick lands on the transition.
    if (state_n != state) begin
      frame_cnt_n = '0;
    end else if (tick && (state == SERVE || state == POINT)) begin
      frame_cnt_n = frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pong_game_ctl.sv
// Scoreboard bench for pong_game_ctl: stimulus queues expected output snapshots,
// a monitor compares one snapshot on every state change.
module tb_pong_game_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vsync_in = 1'b0;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_en, ball_center, serve_dir;
  logic [3:0] score_left, score_right;
  logic [1:0] winner;
  logic [2:0] state_out;

  pong_game_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .vsync_in    (vsync_in),
    .start       (start),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .ball_en     (ball_en),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       ctr;
    logic       dir;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] win;
  } snap_t;

  snap_t      exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m_l = 4'd0;
  logic [3:0] m_r = 4'd0;
  logic       m_dir = 1'b0;
  logic [1:0] m_win = 2'b00;
  bit         mon_en = 1'b0;

  function automatic snap_t model(input logic [2:0] st);
    snap_t s;
    s.st  = st;
    s.en  = (st == 3'd2);
    s.ctr = (st == 3'd0) || (st == 3'd1) || (st == 3'd4);
    s.dir = m_dir;
    s.sl  = m_l;
    s.sr  = m_r;
    s.win = m_win;
    return s;
  endfunction

  task automatic push(input logic [2:0] st);
    exp_q.push_back(model(st));
  endtask

  // Monitor: state, scores, direction and winner at the transition; ball controls one clock later.
  initial begin
    snap_t      got;
    snap_t      want;
    logic [2:0] prev;
    wait (mon_en);
    prev = state_out;
    forever begin
      @(negedge clk);
      if (state_out !== prev) begin
        prev    = state_out;
        got.st  = state_out;
        got.dir = serve_dir;
        got.sl  = score_left;
        got.sr  = score_right;
        got.win = winner;
        @(negedge clk);
        got.en  = ball_en;
        got.ctr = ball_center;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_transition got st=%0d en=%0b ctr=%0b dir=%0b l=%0d r=%0d win=%0b required no transition",
                   got.st, got.en, got.ctr, got.dir, got.sl, got.sr, got.win);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL transition got st=%0d en=%0b ctr=%0b dir=%0b l=%0d r=%0d win=%0b required st=%0d en=%0b ctr=%0b dir=%0b l=%0d r=%0d win=%0b",
                     got.st, got.en, got.ctr, got.dir, got.sl, got.sr, got.win,
                     want.st, want.en, want.ctr, want.dir, want.sl, want.sr, want.win);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending_transitions=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 vsync_in = 1'b1;
      repeat (2) @(posedge clk);
      #1 vsync_in = 1'b0;
      repeat (5) @(posedge clk);
    end
  endtask

  // The transition must appear exactly on the n-th tick, not before.
  task automatic expect_after(input int n, input logic [2:0] st, input string name);
    frames(n - 1);
    push(st);
    frames(1);
    drain(name);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_miss(input logic l, input logic r);
    @(posedge clk); #1 miss_left = l; miss_right = r;
    @(posedge clk); #1 miss_left = 1'b0; miss_right = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", 8'(state_out), 8'd0);
    chk("reset_ball_en", 8'(ball_en), 8'd0);
    chk("reset_ball_center", 8'(ball_center), 8'd1);
    chk("reset_serve_dir", 8'(serve_dir), 8'd0);
    chk("reset_scores", {score_left, score_right}, 8'h00);
    chk("reset_winner", 8'(winner), 8'd0);
    mon_en = 1'b1;

    push(3'd1);
    pulse_start();
    drain("idle_to_serve");
    expect_after(60, 3'd2, "serve_to_play");

    m_r = 4'd1; m_dir = 1'b0;
    push(3'd3);
    pulse_miss(1'b1, 1'b0);
    drain("miss_left_point");
    expect_after(90, 3'd1, "point_to_serve_a");
    expect_after(60, 3'd2, "serve_to_play_a");

    m_l = 4'd1; m_dir = 1'b1;
    push(3'd3);
    pulse_miss(1'b0, 1'b1);
    drain("miss_right_point");
    expect_after(90, 3'd1, "point_to_serve_b");
    expect_after(60, 3'd2, "serve_to_play_b");

    m_dir = 1'b0;
    push(3'd3);
    pulse_miss(1'b1, 1'b1);
    drain("double_miss_point");
    expect_after(90, 3'd1, "point_to_serve_c");
    pulse_miss(1'b1, 1'b0);
    pulse_miss(1'b0, 1'b1);
    pulse_start();
    expect_after(60, 3'd2, "serve_to_play_c");

    for (int i = 2; i <= 5; i++) begin
      m_l = 4'(i); m_dir = 1'b1;
      push(3'd3);
      pulse_miss(1'b0, 1'b1);
      drain("left_scores");
      if (i < 5) begin
        expect_after(90, 3'd1, "point_to_serve_d");
        expect_after(60, 3'd2, "serve_to_play_d");
      end else begin
        m_win = 2'b01;
        expect_after(90, 3'd4, "point_to_over");
      end
    end

    push(3'd0);
    pulse_start();
    drain("over_to_idle");
    m_l = 4'd0; m_r = 4'd0; m_win = 2'b00;
    push(3'd1);
    pulse_start();
    drain("new_game_serve");
    expect_after(60, 3'd2, "serve_to_play_e");

    m_l = 4'd1; m_dir = 1'b1;
    push(3'd3);
    pulse_miss(1'b0, 1'b1);
    drain("miss_right_point_e");
    expect_after(90, 3'd1, "point_to_serve_e");
    expect_after(60, 3'd2, "serve_to_play_f");

    m_l = 4'd0; m_r = 4'd0; m_dir = 1'b0; m_win = 2'b00;
    push(3'd0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("async_rst_state", 8'(state_out), 8'd0);
    chk("async_rst_ball_en", 8'(ball_en), 8'd0);
    chk("async_rst_ball_center", 8'(ball_center), 8'd1);
    chk("async_rst_serve_dir", 8'(serve_dir), 8'd0);
    chk("async_rst_score_left", 8'(score_left), 8'd0);
    @(posedge clk); #1 rst = 1'b0;
    drain("reset_to_idle");

    push(3'd1);
    @(posedge clk); #1 start = 1'b1;
    drain("hold_start_serve");
    expect_after(60, 3'd2, "hold_serve_to_play");
    frames(140);
    @(posedge clk); #1 start = 1'b0;
    drain("hold_no_toggle");
    chk("hold_state_play", 8'(state_out), 8'd2);

`ifdef PONG_PAUSE_EN
    push(3'd5);
    pulse_start();
    drain("play_to_pause");
    pulse_miss(1'b1, 1'b0);
    push(3'd2);
    pulse_start();
    drain("pause_to_play");
    chk("pause_scores", {score_left, score_right}, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
